// File: rtl/controlador_entrada.sv
// controlador_entrada: keyboard/switch read controller for the IN instruction (up to three BCD digits).
// Optional idle timeout enabled by defining ENTRADA_TIMEOUT_EN.
module controlador_entrada #(
    parameter int TIMEOUT_CICLOS = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pedidoIN,
    input  logic        cancela,
    input  logic        botaoIN,
    input  logic [3:0]  entradaDeDados,
    output logic [31:0] dadoLido,
    output logic        dadoValido,
    output logic        pausa,
    output logic [3:0]  unidade,
    output logic [3:0]  dezena,
    output logic [3:0]  centena,
    output logic        erro
);
    typedef enum logic [1:0] {OCIOSO, CAPTURA, ENTREGA} estado_t;

    estado_t     estado, proximo;
    logic        botaoReg;
    logic        evento;
    logic        ehDigito;
    logic        ehEnter;
    logic        fimPorTempo;
    logic [9:0]  acumulador;
    logic [9:0]  lidoReg;
    logic [1:0]  contagem;

    assign evento   = botaoIN & ~botaoReg;
    assign ehDigito = entradaDeDados <= 4'd9;
    assign ehEnter  = entradaDeDados == 4'hF;

`ifdef ENTRADA_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
    logic [CW-1:0] contTempo;

    // Idle-cycle counter: runs only while capturing, restarts on every button event.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            contTempo <= '0;
        else if (estado != CAPTURA || evento)
            contTempo <= '0;
        else
            contTempo <= contTempo + 1'b1;
    end

    assign fimPorTempo = (estado == CAPTURA) && (contTempo == CW'(TIMEOUT_CICLOS - 1));
`else
    assign fimPorTempo = 1'b0 & (TIMEOUT_CICLOS > 0);
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            estado <= OCIOSO;
        else
            estado <= proximo;
    end

    // Next state: cancel beats everything; an event takes precedence over the timeout.
    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:  proximo = pedidoIN ? CAPTURA : OCIOSO;
            CAPTURA: begin
                if (cancela)
                    proximo = OCIOSO;
                else if (evento ? (ehEnter || (ehDigito && contagem == 2'd2)) : fimPorTempo)
                    proximo = ENTREGA;
            end
            ENTREGA: proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    // Datapath: button edge register, digit accumulation, BCD echo, error flag, delivered value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            botaoReg   <= 1'b0;
            acumulador <= '0;
            contagem   <= '0;
            unidade    <= '0;
            dezena     <= '0;
            centena    <= '0;
            erro       <= 1'b0;
            lidoReg    <= '0;
        end else begin
            botaoReg <= botaoIN;
            if (estado == OCIOSO && pedidoIN) begin
                acumulador <= '0;
                contagem   <= '0;
                unidade    <= '0;
                dezena     <= '0;
                centena    <= '0;
                erro       <= 1'b0;
            end else if (estado == CAPTURA && !cancela && evento) begin
                if (ehDigito) begin
                    acumulador <= acumulador * 10'd10 + 10'(entradaDeDados);
                    contagem   <= contagem + 1'b1;
                    centena    <= dezena;
                    dezena     <= unidade;
                    unidade    <= entradaDeDados;
                end else if (!ehEnter) begin
                    erro <= 1'b1;
                end
            end
            if (dadoValido)
                lidoReg <= acumulador;
        end
    end

    // Outputs: the delivered value shows during the completion pulse and is then held.
    always_comb begin
        pausa      = estado == CAPTURA;
        dadoValido = (estado == ENTREGA) && !cancela;
        dadoLido   = {22'd0, dadoValido ? acumulador : lidoReg};
    end
endmodule

// File: tb/tb_controlador_entrada.sv
// tb_controlador_entrada: directed and random reads checked against an arithmetic digit-entry model.
module tb_controlador_entrada;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pedidoIN = 1'b0;
    logic        cancela = 1'b0;
    logic        botaoIN = 1'b0;
    logic [3:0]  entradaDeDados = 4'd0;
    logic [31:0] dadoLido;
    logic        dadoValido;
    logic        pausa;
    logic [3:0]  unidade;
    logic [3:0]  dezena;
    logic [3:0]  centena;
    logic        erro;

    int checks = 0;
    int errors = 0;
    int expLido = 0;
    int q[$];

    controlador_entrada #(.TIMEOUT_CICLOS(8)) dut (
        .clock(clock),
        .reset(reset),
        .pedidoIN(pedidoIN),
        .cancela(cancela),
        .botaoIN(botaoIN),
        .entradaDeDados(entradaDeDados),
        .dadoLido(dadoLido),
        .dadoValido(dadoValido),
        .pausa(pausa),
        .unidade(unidade),
        .dezena(dezena),
        .centena(centena),
        .erro(erro)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkEcho(input int v);
        chk("unidade", unidade, v % 10);
        chk("dezena", dezena, (v / 10) % 10);
        chk("centena", centena, v / 100);
    endtask

    task automatic startRead;
        chk("pausaIdle", pausa, 0);
        pedidoIN = 1'b1;
        tick;
        pedidoIN = 1'b0;
        chk("pausaStart", pausa, 1);
        chk("erroClear", erro, 0);
        chk("validStart", dadoValido, 0);
        chkEcho(0);
    endtask

    task automatic press(input int k, input bit fin, input int v, input bit pend, input bit err);
        entradaDeDados = 4'(k);
        botaoIN = 1'b1;
        tick;
        botaoIN = 1'b0;
        chk("validPress", dadoValido, fin);
        if (fin) chk("lidoPulse", dadoLido, v);
        chk("pausaPress", pausa, pend);
        chk("erroPress", erro, err);
        chkEcho(v);
        tick;
        chk("validOneCycle", dadoValido, 0);
    endtask

    // Model: digits build a decimal number, three digits or enter completes, 10-14 flags an error.
    task automatic runRead;
        int val = 0;
        int n = 0;
        bit err = 0;
        bit done = 0;
        bit just;
        startRead;
        foreach (q[i]) begin
            just = 0;
            if (!done) begin
                if (q[i] <= 9) begin
                    val = val * 10 + q[i];
                    n++;
                    if (n == 3) begin done = 1; just = 1; end
                end else if (q[i] == 15) begin
                    done = 1;
                    just = 1;
                end else begin
                    err = 1;
                end
            end
            if (just) expLido = val;
            press(q[i], just, val, !done, err);
        end
        if (!done) begin
            cancela = 1'b1;
            #1;
            chk("validCancel", dadoValido, 0);
            tick;
            cancela = 1'b0;
            chk("pausaCancel", pausa, 0);
        end
        chk("lidoHeld", dadoLido, expLido);
    endtask

    initial begin
        tick;
        chk("rstLido", dadoLido, 0);
        chk("rstValido", dadoValido, 0);
        chk("rstPausa", pausa, 0);
        chk("rstErro", erro, 0);
        chkEcho(0);
        reset = 1'b0;
        tick;

        q = {4, 2, 15};
        runRead();
        chk("echo42c", centena, 0);
        chk("echo42d", dezena, 4);
        chk("echo42u", unidade, 2);
        chk("lido42", dadoLido, 42);

        q = {9, 9, 9, 9};
        runRead();
        chk("lido999", dadoLido, 999);

        q = {3, 11, 7, 15};
        runRead();
        chk("lido37", dadoLido, 37);
        chk("erroSticky", erro, 1);

        startRead;
        press(5, 0, 5, 1, 0);
        entradaDeDados = 4'd6;
        botaoIN = 1'b1;
        cancela = 1'b1;
        #1;
        chk("validCancelEvt", dadoValido, 0);
        tick;
        botaoIN = 1'b0;
        cancela = 1'b0;
        chk("pausaCancelEvt", pausa, 0);
        chk("lidoKeep", dadoLido, 37);
        chk("validAfterCancel", dadoValido, 0);
        tick;

        botaoIN = 1'b1;
        entradaDeDados = 4'd8;
        tick;
        pedidoIN = 1'b1;
        tick;
        pedidoIN = 1'b0;
        chk("pausaHeld", pausa, 1);
        tick;
        chk("heldNoEvt", unidade, 0);
        chk("heldPausa", pausa, 1);
        botaoIN = 1'b0;
        tick;
        press(15, 1, 0, 0, 0);
        chk("lidoZero", dadoLido, 0);
        expLido = 0;

        for (int r = 0; r < 40; r++) begin
            int nk;
            int sel;
            q.delete();
            nk = $urandom_range(1, 5);
            for (int j = 0; j < nk; j++) begin
                sel = $urandom_range(0, 99);
                q.push_back(sel < 70 ? $urandom_range(0, 9) : (sel < 85 ? 15 : $urandom_range(10, 14)));
            end
            runRead();
        end

`ifdef ENTRADA_TIMEOUT_EN
        startRead;
        press(7, 0, 7, 1, 0);
        for (int i = 2; i <= 8; i++) begin
            tick;
            chk("timeoutPulse", dadoValido, i == 8);
        end
        chk("timeoutLido", dadoLido, 7);
        tick;
        chk("timeoutPausa", pausa, 0);
        expLido = 7;
`endif

        startRead;
        press(1, 0, 1, 1, 0);
        press(2, 0, 12, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("arstLido", dadoLido, 0);
        chk("arstValido", dadoValido, 0);
        chk("arstPausa", pausa, 0);
        chk("arstErro", erro, 0);
        chkEcho(0);
        tick;
        reset = 1'b0;
        tick;
        chk("postRstPausa", pausa, 0);
        chk("postRstValido", dadoValido, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
